// File: rtl/mem_store_buffer_pkg.sv
// Shared types and defaults for the MEM-stage store buffer.
package mem_pkg;

  localparam int DEPTH_DEFAULT  = 4;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam int PTR_W          = $clog2(DEPTH_DEFAULT);

  typedef struct packed {
    logic [ADDR_W_DEFAULT-3:0] word_addr;
    logic [DATA_W_DEFAULT-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Finds the youngest buffered store whose word address matches a load.
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  sb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [ADDR_W_DEFAULT-3:0]    load_waddr,
  output logic                         hit,
  output logic [DATA_W_DEFAULT-1:0]    hit_data
);

  localparam int IW = $clog2(DEPTH);

  // Walking oldest to youngest and letting later hits override gives the
  // same winner as a youngest-first scan from tail-1.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[head + IW'(k)] && entries[head + IW'(k)].word_addr == load_waddr) begin
        hit      = 1'b1;
        hit_data = entries[head + IW'(k)].data;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store FIFO between the MEM stage and data memory; loads own the port
// and forward from the youngest matching buffered store.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     stall,
  output logic [DATA_W-1:0]        load_data,
  output logic                     load_fwd,
  output logic                     req_err,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IW = $clog2(DEPTH);

  sb_entry_t              entries [DEPTH];
  sb_entry_t              head_entry;
  logic [IW-1:0]          head;
  logic [IW-1:0]          tail;
  logic [DEPTH-1:0]       valid;
  logic                   bad_req;
  logic                   load_ok;
  logic                   store_ok;
  logic                   full;
  logic                   enq;
  logic                   drain;
  logic                   hit;
  logic [DATA_W_DEFAULT-1:0] hit_data;

  // Erroneous requests are dropped entirely and also keep the port quiet.
  assign bad_req  = ((req_read || req_write) && (req_addr[1:0] != 2'b00)) ||
                    (req_read && req_write);
  assign load_ok  = req_read && !bad_req;
  assign store_ok = req_write && !bad_req;
  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign enq      = store_ok && !full;
  assign drain    = !load_ok && !bad_req && (count != '0);

  assign head_entry = entries[head];
  assign empty      = (count == '0);
  assign req_err    = reset && bad_req;
  assign stall      = reset && store_ok && full;

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, IW'(i) - head} < count);
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries    (entries),
    .valid      (valid),
    .head       (head),
    .load_waddr (req_addr[ADDR_W-1:2]),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + IW'(1);
      if (drain) head <= head + IW'(1);
      if (enq && !drain)      count <= count + 1'b1;
      else if (drain && !enq) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= '{word_addr: req_addr[ADDR_W-1:2], data: req_wdata};
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load_data = '0;
    load_fwd  = 1'b0;
    if (reset) begin
      if (load_ok) begin
        load_fwd  = hit;
        mem_read  = !hit;
        load_data = hit ? hit_data : mem_rdata;
        if (!hit) mem_addr = req_addr;
      end else if (drain) begin
        mem_write = 1'b1;
        mem_addr  = {head_entry.word_addr, 2'b00};
        mem_wdata = head_entry.data;
      end
    end
  end

endmodule
